blob_bbox_collector: RTL

//  Downstream of the pixel pipeline's connected-components stage: consumes the per-pixel

---
 rtl/blob_bbox_collector.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/blob_bbox_collector.sv
// Per-label bounding-box collector: accumulates boxes over a frame, drains them
// on vsync, then clears. Define BLOB_BBOX_AREA_EN to add a per-label pixel count.
module blob_bbox_collector #(
  parameter int NUM_LABELS  = 64,
  parameter int LABEL_WIDTH = 8,
  parameter int COORD_WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     vsync,
  input  logic [31:0]              x,
  input  logic [31:0]              y,
  input  logic [LABEL_WIDTH-1:0]   label,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LABEL_WIDTH-1:0]   out_label,
  output logic [COORD_WIDTH-1:0]   out_xmin,
  output logic [COORD_WIDTH-1:0]   out_xmax,
  output logic [COORD_WIDTH-1:0]   out_ymin,
  output logic [COORD_WIDTH-1:0]   out_ymax,
`ifdef BLOB_BBOX_AREA_EN
  output logic [2*COORD_WIDTH-1:0] out_area,
`endif
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int IDX_W = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;

  typedef enum logic [1:0] {ACCUM, DRAIN, CLEAR} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_LABELS-1:0]   valid_q, valid_d;
  logic                    vsync_q, vsync_d;
  logic                    overflow_q, overflow_d;

  logic [COORD_WIDTH-1:0]  xmin_q [NUM_LABELS];
  logic [COORD_WIDTH-1:0]  xmax_q [NUM_LABELS];
  logic [COORD_WIDTH-1:0]  ymin_q [NUM_LABELS];
  logic [COORD_WIDTH-1:0]  ymax_q [NUM_LABELS];

  logic                    wr_en;
  logic [IDX_W-1:0]        wr_idx;
  logic [COORD_WIDTH-1:0]  wr_xmin, wr_xmax, wr_ymin, wr_ymax;

  logic [COORD_WIDTH-1:0]  px, py;
  logic [IDX_W-1:0]        lbl_idx;
  logic                    lbl_nz, lbl_in_range, vsync_rise, drain_hit;
  logic                    unused_bits;

`ifdef BLOB_BBOX_AREA_EN
  logic [2*COORD_WIDTH-1:0] area_q [NUM_LABELS];
  logic [2*COORD_WIDTH-1:0] wr_area;
`endif

  assign px           = x[COORD_WIDTH-1:0];
  assign py           = y[COORD_WIDTH-1:0];
  assign lbl_idx      = label[IDX_W-1:0];
  assign lbl_nz       = |label;
  assign lbl_in_range = 32'(label) < NUM_LABELS;
  assign vsync_rise   = vsync & ~vsync_q;
  assign unused_bits  = ^{x[31:COORD_WIDTH], y[31:COORD_WIDTH]};

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    vsync_d    = vsync;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_idx     = lbl_idx;
    wr_xmin    = px;
    wr_xmax    = px;
    wr_ymin    = py;
    wr_ymax    = py;
`ifdef BLOB_BBOX_AREA_EN
    wr_area    = {{(2*COORD_WIDTH-1){1'b0}}, 1'b1};
`endif
    unique case (state_q)
      ACCUM: begin
        if (en && lbl_nz) begin
          if (lbl_in_range) begin
            wr_en            = 1'b1;
            valid_d[lbl_idx] = 1'b1;
            if (valid_q[lbl_idx]) begin
              wr_xmin = (px < xmin_q[lbl_idx]) ? px : xmin_q[lbl_idx];
              wr_xmax = (px > xmax_q[lbl_idx]) ? px : xmax_q[lbl_idx];
              wr_ymin = (py < ymin_q[lbl_idx]) ? py : ymin_q[lbl_idx];
              wr_ymax = (py > ymax_q[lbl_idx]) ? py : ymax_q[lbl_idx];
`ifdef BLOB_BBOX_AREA_EN
              wr_area = (&area_q[lbl_idx]) ? area_q[lbl_idx] : area_q[lbl_idx] + 1'b1;
`endif
            end
          end else begin
            overflow_d = 1'b1;
          end
        end
        // Label 0 is background, so the drain starts at entry 1.
        if (vsync_rise) begin
          state_d = DRAIN;
          idx_d   = IDX_W'(1);
        end
      end
      DRAIN: begin
        if (en && lbl_nz) overflow_d = 1'b1;
        if (!valid_q[idx_q] || out_ready) begin
          if (idx_q == IDX_W'(NUM_LABELS - 1)) begin
            state_d = CLEAR;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        valid_d    = '0;
        overflow_d = en && lbl_nz;
        state_d    = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ACCUM;
      idx_q      <= '0;
      valid_q    <= '0;
      vsync_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      vsync_q    <= vsync_d;
      overflow_q <= overflow_d;
    end
  end

  // Box storage needs no reset: entries are only read while their valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      xmin_q[wr_idx] <= wr_xmin;
      xmax_q[wr_idx] <= wr_xmax;
      ymin_q[wr_idx] <= wr_ymin;
      ymax_q[wr_idx] <= wr_ymax;
`ifdef BLOB_BBOX_AREA_EN
      area_q[wr_idx] <= wr_area;
`endif
    end
  end

  // Outputs decode straight from registered state, so reset drops them at once.
  always_comb begin
    drain_hit  = (state_q == DRAIN) && valid_q[idx_q];
    out_valid  = drain_hit;
    out_label  = drain_hit ? LABEL_WIDTH'(idx_q) : '0;
    out_xmin   = drain_hit ? xmin_q[idx_q] : '0;
    out_xmax   = drain_hit ? xmax_q[idx_q] : '0;
    out_ymin   = drain_hit ? ymin_q[idx_q] : '0;
    out_ymax   = drain_hit ? ymax_q[idx_q] : '0;
`ifdef BLOB_BBOX_AREA_EN
    out_area   = drain_hit ? area_q[idx_q] : '0;
`endif
    busy       = (state_q == DRAIN);
    frame_done = (state_q == CLEAR);
    overflow   = overflow_q;
  end

endmodule
